cby_param_cfg: RTL

//  Parametrised Y-channel connection block: feeds CHAN_W tracks straight through in both directions and drives
//  NUM_IPIN grid input pins via per-pin routing muxes of MUX_SIZE inputs.
//  Mux selects live in a double-buffered config store (shadow + active) written through an addressed handshake port.

---
 rtl/cby_param_cfg.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cby_param_cfg.sv
// Purpose  : Y-channel connection block. Tracks pass straight through; NUM_IPIN pin muxes tap the channel.
// Latency  : pass-through and ipin paths are combinational; cfg read data/err 1 cycle after transfer.
// Backpress: cfg_ready low in RESET and COMMIT; requester must hold cfg_valid until accepted.
//
// Ports:
//   prog_clk / prog_reset            config clock, synchronous active-high reset
//   chany_{bottom,top}_in/_out       CHAN_W tracks each way; outputs are the opposite side's inputs
//   ipin_out[NUM_IPIN]               grid pin drivers, muxed by the active select registers
//   cfg_valid/ready/we/addr/wdata    addressed shadow read/write port (valid-ready)
//   cfg_commit                       copy every shadow select into the active set
//   cfg_rdata/rvalid/err/pending     read return, out-of-range pulse, shadow-dirty flag
module cby_param_cfg #(
  parameter  int CHAN_W   = 9,
  parameter  int NUM_IPIN = 5,
  parameter  int MUX_SIZE = 6,
  parameter  int STRIDE   = 1,
  localparam int SEL_W    = $clog2(MUX_SIZE),
  localparam int ADDR_W   = (NUM_IPIN > 1) ? $clog2(NUM_IPIN) : 1
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic [CHAN_W-1:0] chany_bottom_in,
  input  logic [CHAN_W-1:0] chany_top_in,
  output logic [CHAN_W-1:0] chany_bottom_out,
  output logic [CHAN_W-1:0] chany_top_out,
  output logic [NUM_IPIN-1:0] ipin_out,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [SEL_W-1:0]  cfg_wdata,
  input  logic              cfg_commit,
  output logic [SEL_W-1:0]  cfg_rdata,
  output logic              cfg_rvalid,
  output logic              cfg_err,
  output logic              cfg_pending
);

  // Mux input vector is padded to a power of two; padded slots read as 0 so
  // select codes >= MUX_SIZE drive the pin low without a separate compare.
  localparam int MUX_PAD = 1 << SEL_W;
  localparam logic [ADDR_W:0] NUM_IPIN_V = (ADDR_W+1)'(NUM_IPIN);

  typedef enum logic [1:0] {S_RESET, S_IDLE, S_COMMIT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_ready;
  logic              w_xfer;
  logic              w_addr_ok;
  logic              w_wr;
  logic              w_rd;
  logic              w_commit;
  logic [SEL_W-1:0]  r_shadow     [NUM_IPIN];
  logic [SEL_W-1:0]  r_active     [NUM_IPIN];
  logic [SEL_W-1:0]  w_shadow_nxt [NUM_IPIN];
  logic [MUX_PAD-1:0] w_mux_in    [NUM_IPIN];
  logic [SEL_W-1:0]  r_rdata;
  logic              r_rvalid;
  logic              r_err;
  logic              r_pending;

  // Pass-through tracks are plain wires, independent of reset and config.
  assign chany_bottom_out = chany_top_in;
  assign chany_top_out    = chany_bottom_in;

  // ---------------- control FSM ----------------
  always_ff @(posedge prog_clk) begin
    if (prog_reset) r_state <= S_RESET;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_RESET:  w_state_nxt = S_IDLE;
      S_IDLE: begin
        w_ready = 1'b1;
        if (cfg_commit) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_RESET;
    endcase
  end

  assign cfg_ready = w_ready;
  assign w_commit  = (r_state == S_IDLE) && cfg_commit;
  assign w_xfer    = cfg_valid && w_ready;
  assign w_addr_ok = {1'b0, cfg_addr} < NUM_IPIN_V;
  assign w_wr      = w_xfer && cfg_we && w_addr_ok;
  assign w_rd      = w_xfer && !cfg_we && w_addr_ok;

  // Shadow contents after this edge; commit copies from here so a write
  // landing in the same cycle as the commit is included.
  always_comb begin
    for (int i = 0; i < NUM_IPIN; i++) begin
      w_shadow_nxt[i] = r_shadow[i];
      if (w_wr && (cfg_addr == ADDR_W'(i))) w_shadow_nxt[i] = cfg_wdata;
    end
  end

  // ---------------- config store ----------------
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_shadow  <= '{default: '0};
      r_active  <= '{default: '0};
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_shadow <= w_shadow_nxt;
      r_rvalid <= w_rd;
      r_err    <= w_xfer && !w_addr_ok;
      if (w_rd) r_rdata <= r_shadow[cfg_addr];
      if (w_commit) begin
        r_active  <= w_shadow_nxt;
        r_pending <= 1'b0;
      end else if (w_wr) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign cfg_rdata   = r_rdata;
  assign cfg_rvalid  = r_rvalid;
  assign cfg_err     = r_err;
  assign cfg_pending = r_pending;

  // ---------------- pin muxes ----------------
  // Input j of pin i taps track (i*STRIDE + j/2) mod CHAN_W: even j from the
  // bottom side, odd j from the top side.
  for (genvar gi = 0; gi < NUM_IPIN; gi++) begin : g_pin
    for (genvar gj = 0; gj < MUX_PAD; gj++) begin : g_tap
      if (gj < MUX_SIZE) begin : g_real
        localparam int T = (gi * STRIDE + gj / 2) % CHAN_W;
        if (gj % 2 == 0) begin : g_bot
          assign w_mux_in[gi][gj] = chany_bottom_in[T];
        end else begin : g_top
          assign w_mux_in[gi][gj] = chany_top_in[T];
        end
      end else begin : g_pad
        assign w_mux_in[gi][gj] = 1'b0;
      end
    end
    assign ipin_out[gi] = w_mux_in[gi][r_active[gi]];
  end

endmodule
